// File: rtl/pdh_gpio_cmd_ctrl.sv
// PS GPIO command sequencer: synchronises the toggle-strobed command word,
// executes register writes/reads on the config bank and returns a toggle-acked response.
//
// Ports:
//   clk, rst        pdh_clk and synchronous active-high reset
//   axi_from_ps_i   cmd  [31] strobe toggle, [30] rw (1=write), [29:26] addr, [15:0] wdata
//   axi_to_ps_o     rsp  [31] ack toggle, [30] err, [29:26] addr echo, [15:0] rdata
//   status_i        live status word, read at address 15
//   cfg_o           config bank, reg k at [16k+15:16k]
//   cfg_wr_o        one-cycle pulse per successful write
//   cfg_addr_o      address of the last write
//   busy_o          high whenever the sequencer is not idle
module pdh_gpio_cmd_ctrl #(
    parameter int NUM_REGS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              axi_from_ps_i,
    output logic [31:0]              axi_to_ps_o,
    input  logic [15:0]              status_i,
    output logic [NUM_REGS*16-1:0]   cfg_o,
    output logic                     cfg_wr_o,
    output logic [3:0]               cfg_addr_o,
    output logic                     busy_o
);

    localparam int CNT_MAX =
        (SYNC_STAGES > SETTLE_CYCLES) ? SYNC_STAGES : SETTLE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST   = CW'(SYNC_STAGES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [4:0]    NREGS       = 5'(NUM_REGS);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETTLE,
        S_EXEC,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_done, capture, exec, ack;

    logic [31:0]     sync_q [SYNC_STAGES];
    logic [31:0]     sync_w;
    logic            last_strb_q;

    logic            cmd_rw_q;
    logic [3:0]      cmd_addr_q;
    logic [15:0]     cmd_wdata_q;

    logic [15:0]     cfg_q [NUM_REGS];
    logic            err_q;
    logic [15:0]     rdata_q;

    logic            in_bank, wr_ok, rd_ok, rd_status;
    logic [15:0]     rd_bank;

    // Reserved command bits are synchronised with the rest but never used.
    logic            unused_rsvd;

    assign sync_w      = sync_q[SYNC_STAGES-1];
    assign unused_rsvd = ^sync_w[25:16];
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_done = 1'b0;
        capture   = 1'b0;
        exec      = 1'b0;
        ack       = 1'b0;
        unique case (state_q)
            S_INIT: begin
                // Wait until the sync chain holds a real input sample.
                if (cnt_q == INIT_LAST) begin
                    init_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (sync_w[31] != last_strb_q) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    capture = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                exec    = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                ack     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign in_bank   = ({1'b0, cmd_addr_q} < NREGS);
    assign wr_ok     = cmd_rw_q & in_bank;
    assign rd_ok     = ~cmd_rw_q & in_bank;
    assign rd_status = ~cmd_rw_q & (cmd_addr_q == 4'hF);

    always_comb begin
        rd_bank = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_addr_q == 4'(k)) rd_bank = cfg_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int k = 0; k < NUM_REGS; k++) cfg_q[k] <= '0;
            last_strb_q <= 1'b0;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            cfg_wr_o    <= 1'b0;
            cfg_addr_o  <= '0;
            axi_to_ps_o <= '0;
        end else begin
            sync_q[0] <= axi_from_ps_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];

            cfg_wr_o <= 1'b0;

            // Adopt the strobe level seen at reset so it is not executed.
            if (init_done) begin
                last_strb_q     <= sync_w[31];
                axi_to_ps_o[31] <= sync_w[31];
            end

            if (capture) begin
                last_strb_q <= sync_w[31];
                cmd_rw_q    <= sync_w[30];
                cmd_addr_q  <= sync_w[29:26];
                cmd_wdata_q <= sync_w[15:0];
            end

            if (exec) begin
                unique case (1'b1)
                    wr_ok: begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (cmd_addr_q == 4'(k)) cfg_q[k] <= cmd_wdata_q;
                        end
                        cfg_wr_o   <= 1'b1;
                        cfg_addr_o <= cmd_addr_q;
                        err_q      <= 1'b0;
                        rdata_q    <= cmd_wdata_q;
                    end
                    rd_ok: begin
                        err_q   <= 1'b0;
                        rdata_q <= rd_bank;
                    end
                    rd_status: begin
                        err_q   <= 1'b0;
                        rdata_q <= status_i;
                    end
                    default: begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                endcase
            end

            // Whole response updates at once so the PS sees coherent fields.
            if (ack) begin
                axi_to_ps_o <= {last_strb_q, err_q, cmd_addr_q, 10'b0, rdata_q};
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
        assign cfg_o[16*k +: 16] = cfg_q[k];
    end

endmodule

// File: tb/tb_pdh_gpio_cmd_ctrl.sv
// Self-checking bench for pdh_gpio_cmd_ctrl: timeline model driven by the
// command latency rules, per-cycle compare, plus literal response checks.
module tb_pdh_gpio_cmd_ctrl;

    localparam int NR = 8;
    localparam int SS = 2;
    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic [15:0]       status;
    logic [NR*16-1:0]  cfg;
    logic              cfg_wr;
    logic [3:0]        cfg_addr;
    logic              busy;

    always #5 clk = ~clk;

    pdh_gpio_cmd_ctrl #(
        .NUM_REGS      (NR),
        .SYNC_STAGES   (SS),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_from_ps_i (din),
        .axi_to_ps_o   (dout),
        .status_i      (status),
        .cfg_o         (cfg),
        .cfg_wr_o      (cfg_wr),
        .cfg_addr_o    (cfg_addr),
        .busy_o        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    logic [31:0] e_rsp;
    logic [15:0] e_cfg [NR];
    logic        e_wr;
    logic [3:0]  e_waddr;
    logic        e_busy;
    logic [15:0] arch [NR];
    int          init_left = 0;
    int          free_at   = 0;
    logic        strb;

    typedef struct {
        int          at;
        int          kind;
        int          idx;
        logic [31:0] val;
    } ev_t;
    ev_t evq[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int at, input int kind,
                                 input int idx, input logic [31:0] val);
        ev_t e;
        e.at = at; e.kind = kind; e.idx = idx; e.val = val;
        evq.push_back(e);
    endfunction

    // Expected state after each rising edge.
    initial forever begin
        ev_t keep[$];
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                e_cfg[k] = '0;
                arch[k]  = '0;
            end
            e_rsp = '0; e_wr = 0; e_waddr = '0; e_busy = 1;
            init_left = SS + 1;
            evq.delete();
        end else begin
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0) begin
                    e_rsp[31] = strb;
                    e_busy    = 0;
                    free_at   = cyc;
                end
            end
            keep = {};
            foreach (evq[i]) begin
                if (evq[i].at == cyc) begin
                    case (evq[i].kind)
                        0: e_cfg[evq[i].idx] = evq[i].val[15:0];
                        1: e_wr = evq[i].val[0];
                        2: e_waddr = evq[i].val[3:0];
                        3: e_busy = evq[i].val[0];
                        default: e_rsp = evq[i].val;
                    endcase
                end else begin
                    keep.push_back(evq[i]);
                end
            end
            evq = keep;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("rsp", dout, e_rsp);
            for (int k = 0; k < NR; k++)
                check($sformatf("cfg%0d", k), 32'(cfg[16*k +: 16]),
                      32'(e_cfg[k]));
            check("cfg_wr", 32'(cfg_wr), 32'(e_wr));
            check("cfg_addr", 32'(cfg_addr), 32'(e_waddr));
            check("busy", 32'(busy), 32'(e_busy));
        end
    end

    // Toggle the strobe and schedule the expected effects.
    task automatic issue(input logic rw, input logic [3:0] a,
                         input logic [15:0] d);
        int t = cyc;
        int se;
        logic err;
        logic [15:0] rd;
        strb = ~strb;
        din  = {strb, rw, a, 10'h2A5, d};
        se = (t + 3 > free_at + 1) ? t + 3 : free_at + 1;
        if (rw && a < NR) begin
            arch[a] = d; err = 0; rd = d;
            push(se + 5, 0, int'(a), 32'(d));
            push(se + 5, 1, 0, 1);
            push(se + 5, 2, 0, 32'(a));
            push(se + 6, 1, 0, 0);
        end else if (!rw && a < NR) begin
            err = 0; rd = arch[a];
        end else if (!rw && a == 4'hF) begin
            err = 0; rd = status;
        end else begin
            err = 1; rd = '0;
        end
        push(se, 3, 0, 1);
        push(se + 6, 3, 0, 0);
        push(se + 6, 4, 0, {strb, err, a, 10'b0, rd});
        free_at = se + 6;
    endtask

    task automatic wait_ack(input logic lvl, input int t0, output int lat);
        int n = 0;
        while (dout[31] !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t0;
        if (dout[31] !== lvl) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got %b expected %b", dout[31], lvl);
        end
    endtask

    task automatic cmd(input string name, input logic rw,
                       input logic [3:0] a, input logic [15:0] d,
                       input logic [31:0] exp_rsp);
        int t0 = cyc;
        int lat;
        issue(rw, a, d);
        wait_ack(strb, t0, lat);
        check({name, "_lat"}, 32'(lat), 32'(SS + SC + 3));
        check({name, "_rsp"}, dout, exp_rsp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0, lat;
        rst = 1; strb = 1; status = 16'h1234;
        din = {1'b1, 31'b0};
        @(negedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);
        check("post_rst_rsp", dout, 32'h8000_0000);
        check("post_rst_cfg", cfg[31:0], 32'h0);

        cmd("w3", 1, 4'd3, 16'hBEEF, 32'h0C00_BEEF);
        check("reg3", 32'(cfg[63:48]), 32'h0000_BEEF);
        cmd("r3", 0, 4'd3, 16'h0000, 32'h8C00_BEEF);
        cmd("r15", 0, 4'd15, 16'h0000, 32'h3C00_1234);
        cmd("w15", 1, 4'd15, 16'h5555, 32'hFC00_0000);
        cmd("w8", 1, 4'd8, 16'h1111, 32'h6000_0000);
        check("reg3_kept", 32'(cfg[63:48]), 32'h0000_BEEF);

        cmd("w0", 1, 4'd0, 16'hA5A5, 32'h8000_A5A5);

        // Second toggle lands while the first command is still busy.
        t0 = cyc;
        issue(1, 4'd5, 16'h0055);
        repeat (6) @(negedge clk);
        issue(0, 4'd5, 16'h0000);
        wait_ack(~strb, t0, lat);
        check("busy_first_lat", 32'(lat), 32'(SS + SC + 3));
        wait_ack(strb, t0, lat);
        check("busy_second_lat", 32'(lat), 32'd16);
        check("busy_second_rsp", dout, 32'h9400_0055);
        repeat (2) @(negedge clk);

        // Reset in the middle of a pending write.
        issue(1, 4'd1, 16'h7777);
        repeat (4) @(negedge clk);
        check("settle_busy", 32'(busy), 32'd1);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_init_busy", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        check("rst_reg1", 32'(cfg[31:16]), 32'h0);
        check("rst_rsp", dout, 32'h0000_0000);

        cmd("w2", 1, 4'd2, 16'h0F0F, 32'h8800_0F0F);
        check("reg2", 32'(cfg[47:32]), 32'h0000_0F0F);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
